plot_receiver: RTL and testbench



---
 rtl/plot_receiver.sv | 156 +++++++++++++++
 tb/tb_plot_receiver.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plot_receiver.sv
// rtl/plot_receiver.sv - pixel plot receiver: address stage, show-ahead FIFO, stallable frame-buffer write port
//
// Optional feature macro: PLOT_RX_CLIP_EN (range clipping plus drop counter).
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   plot, x, y, colour  plot offer from a drawer; taken when plot && plot_ready
//   plot_ready          block can take a plot this cycle
//   fb_we, fb_addr,     frame-buffer write presented from the FIFO head,
//   fb_data, fb_ready   popped when fb_we && fb_ready
//   idle                nothing staged or buffered
//   drop_count          saturating count of clipped plots (0 without clipping)
module plot_receiver #(
    parameter int DEPTH     = 8,
    parameter int WIDTH_PX  = 160,
    parameter int HEIGHT_PX = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        plot,
    input  logic [7:0]  x,
    input  logic [6:0]  y,
    input  logic [2:0]  colour,
    output logic        plot_ready,
    output logic        fb_we,
    output logic [14:0] fb_addr,
    output logic [2:0]  fb_data,
    input  logic        fb_ready,
    output logic        idle,
    output logic [7:0]  drop_count
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW      = AW + 1;
    localparam logic [14:0] WIDTH_W = 15'(WIDTH_PX);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [14:0]   addr_calc;
    logic          accept;

    logic          s1_valid;
    logic [14:0]   s1_addr;
    logic [2:0]    s1_colour;
    logic          s1_oor;
    logic          s1_free;

    logic [17:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic [17:0]   head;

    // Linear address; 15 bits is enough for any 7-bit row at 160 columns.
    assign addr_calc = {8'd0, y} * WIDTH_W + {7'd0, x};

    // The ready test counts stage 1 plus the FIFO against DEPTH inclusively,
    // so the block holds DEPTH+1 plots in total: a full FIFO plus one entry
    // parked in stage 1. A parked entry waits for the next pop.
    assign plot_ready = ({1'b0, count} + {{CW{1'b0}}, s1_valid}) <= DEPTH_W;
    assign accept     = plot && plot_ready;

    assign fifo_full  = (count == CW'(DEPTH));
    assign pop        = fb_we && fb_ready;
    assign push       = s1_valid && !s1_oor && (!fifo_full || pop);
    // Stage 1 empties when it is pushed, or when its entry is clipped away.
    assign s1_free    = !s1_valid || s1_oor || push;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_addr   <= 15'd0;
            s1_colour <= 3'd0;
        end else if (accept) begin
            s1_valid  <= 1'b1;
            s1_addr   <= addr_calc;
            s1_colour <= colour;
        end else if (s1_free) begin
            s1_valid  <= 1'b0;
        end
    end

`ifdef PLOT_RX_CLIP_EN
    localparam logic [8:0] WIDTH_LIM  = 9'(WIDTH_PX);
    localparam logic [7:0] HEIGHT_LIM = 8'(HEIGHT_PX);

    logic       oor_calc;
    logic       s1_oor_q;
    logic [7:0] drop_q;

    assign oor_calc = ({1'b0, x} >= WIDTH_LIM) || ({1'b0, y} >= HEIGHT_LIM);
    assign s1_oor   = s1_oor_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_oor_q <= 1'b0;
        end else if (accept) begin
            s1_oor_q <= oor_calc;
        end
    end

    // Each clipped entry sits in stage 1 for exactly one cycle, so it is
    // counted once.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_q <= 8'd0;
        end else if (s1_valid && s1_oor_q && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign drop_count = drop_q;
`else
    localparam int unused_height_px = HEIGHT_PX;

    assign s1_oor     = 1'b0;
    assign drop_count = 8'd0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // When full, a push only happens alongside a pop; wr_ptr then equals
    // rd_ptr and the slot being written is the one being vacated.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {s1_addr, s1_colour};
        end
    end

    assign head    = mem[rd_ptr];
    assign fb_we   = (count != '0);
    assign fb_addr = fb_we ? head[17:3] : 15'd0;
    assign fb_data = fb_we ? head[2:0]  : 3'd0;
    assign idle    = !s1_valid && (count == '0);

endmodule

// File: tb/tb_plot_receiver.sv
// tb/tb_plot_receiver.sv - self-checking bench for plot_receiver
module tb_plot_receiver;

    localparam int DEPTH     = 8;
    localparam int WIDTH_PX  = 160;
    localparam int HEIGHT_PX = 120;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        plot = 1'b0;
    logic [7:0]  x = 8'd0;
    logic [6:0]  y = 7'd0;
    logic [2:0]  colour = 3'd0;
    logic        plot_ready;
    logic        fb_we;
    logic [14:0] fb_addr;
    logic [2:0]  fb_data;
    logic        fb_ready = 1'b0;
    logic        idle;
    logic [7:0]  drop_count;

    plot_receiver #(
        .DEPTH     (DEPTH),
        .WIDTH_PX  (WIDTH_PX),
        .HEIGHT_PX (HEIGHT_PX)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .plot       (plot),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot_ready (plot_ready),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .fb_ready   (fb_ready),
        .idle       (idle),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [14:0] addr;
        logic [2:0]  col;
    } wr_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    wr_t         exp_q[$];
    logic [14:0] wr_log[$];
    int          wr_count = 0;
    int          first_wr = -1;
    int          last_wr = -1;
    int          cyc = 0;
    int          drop_model = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit out_of_range(input int px, input int py);
`ifdef PLOT_RX_CLIP_EN
        return (px >= WIDTH_PX) || (py >= HEIGHT_PX);
`else
        return 1'b0;
`endif
    endfunction

    // Reference model: every accepted, in-range plot becomes one write, in
    // acceptance order, at row*width+column.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            exp_q.delete();
            drop_model = 0;
        end else begin
            if (fb_we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(fb_we), 32'd0);
                end else begin
                    check("fb_addr", 32'(fb_addr), 32'(exp_q[0].addr));
                    check("fb_data", 32'(fb_data), 32'(exp_q[0].col));
                    if (fb_ready) begin
                        void'(exp_q.pop_front());
                        wr_log.push_back(fb_addr);
                        wr_count++;
                        if (first_wr < 0) first_wr = cyc;
                        last_wr = cyc;
                    end
                end
            end
            if (plot && plot_ready) begin
                if (out_of_range(int'(x), int'(y))) begin
                    if (drop_model < 255) drop_model++;
                end else begin
                    exp_q.push_back('{addr: 15'((int'(y) * WIDTH_PX + int'(x)) % 32768), col: colour});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic clear_stats();
        wr_count = 0;
        first_wr = -1;
        last_wr  = -1;
        wr_log.delete();
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        fb_ready = 1'b1;
        while (!idle && n < 200) begin
            tick();
            n++;
        end
        tick();
        if (n >= 200) check({tag, "_drain_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic offer(input int px, input int py, input int col);
        plot   = 1'b1;
        x      = 8'(px);
        y      = 7'(py);
        colour = 3'(col);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_acc;

        // Reset state
        tick();
        do_reset();
        check("rst_fb_we", 32'(fb_we), 32'd0);
        check("rst_fb_addr", 32'(fb_addr), 32'd0);
        check("rst_fb_data", 32'(fb_data), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_plot_ready", 32'(plot_ready), 32'd1);
        check("rst_drop", 32'(drop_count), 32'd0);

        // Single plot latency: accepted at edge k, written after edge k+1, one cycle
        clear_stats();
        fb_ready = 1'b1;
        offer(10, 10, 7);
        tick();
        plot = 1'b0;
        check("single_we_k", 32'(fb_we), 32'd0);
        tick();
        check("single_we_k1", 32'(fb_we), 32'd1);
        check("single_addr", 32'(fb_addr), 32'd1610);
        check("single_data", 32'(fb_data), 32'd7);
        tick();
        check("single_we_k2", 32'(fb_we), 32'd0);
        check("single_idle", 32'(idle), 32'd1);
        check("single_count", 32'(wr_count), 32'd1);

        // Burst of 66 in-range plots at full rate
        clear_stats();
        for (int i = 0; i < 66; i++) begin
            offer($urandom_range(0, 159), $urandom_range(0, 119), $urandom_range(0, 7));
            check("burst_ready", 32'(plot_ready), 32'd1);
            tick();
        end
        plot = 1'b0;
        drain("burst");
        check("burst_writes", 32'(wr_count), 32'd66);
        check("burst_no_gaps", 32'(last_wr - first_wr + 1), 32'd66);

        // Backpressure: exactly DEPTH+1 accepted, then drain in order
        clear_stats();
        fb_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 15; i++) begin
            offer($urandom_range(0, 159), $urandom_range(0, 119), $urandom_range(0, 7));
            if (plot_ready) n_acc++;
            tick();
        end
        plot = 1'b0;
        check("bp_accepts", 32'(n_acc), 32'(DEPTH + 1));
        check("bp_ready_low", 32'(plot_ready), 32'd0);
        fb_ready = 1'b1;
        tick();
        check("bp_ready_after_pop", 32'(plot_ready), 32'd1);
        drain("bp");
        check("bp_writes", 32'(wr_count), 32'(DEPTH + 1));

        // Boundary addresses
        clear_stats();
        offer(159, 119, 5);
        tick();
        offer(0, 0, 2);
        tick();
        plot = 1'b0;
        drain("bound");
        check("bound_count", 32'(wr_count), 32'd2);
        if (wr_log.size() == 2) begin
            check("bound_max", 32'(wr_log[0]), 32'd19199);
            check("bound_zero", 32'(wr_log[1]), 32'd0);
        end

        // Clipping
        clear_stats();
        offer(160, 5, 1);
        tick();
        offer(3, 120, 1);
        tick();
        plot = 1'b0;
        drain("clip");
`ifdef PLOT_RX_CLIP_EN
        check("clip_writes", 32'(wr_count), 32'd0);
        check("clip_drop2", 32'(drop_count), 32'd2);
        for (int i = 0; i < 300; i++) begin
            offer($urandom_range(160, 255), $urandom_range(0, 127), $urandom_range(0, 7));
            tick();
        end
        plot = 1'b0;
        drain("clip_sat");
        check("clip_drop_sat", 32'(drop_count), 32'd255);
`else
        check("noclip_writes", 32'(wr_count), 32'd2);
        if (wr_log.size() > 0) check("noclip_addr", 32'(wr_log[0]), 32'd960);
        check("noclip_drop", 32'(drop_count), 32'd0);
`endif

        // Reset mid-burst with 5 buffered
        clear_stats();
        fb_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            offer($urandom_range(0, 159), $urandom_range(0, 119), $urandom_range(0, 7));
            tick();
        end
        plot = 1'b0;
        tick();
        do_reset();
        fb_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("mid_rst_we", 32'(fb_we), 32'd0);
            check("mid_rst_idle", 32'(idle), 32'd1);
            check("mid_rst_ready", 32'(plot_ready), 32'd1);
            tick();
        end
        check("mid_rst_drop", 32'(drop_count), 32'd0);
        check("mid_rst_writes", 32'(wr_count), 32'd0);

        // Reset together with plot: nothing accepted
        reset = 1'b1;
        offer(20, 20, 3);
        tick();
        reset = 1'b0;
        plot  = 1'b0;
        tick();
        tick();
        check("rst_plot_idle", 32'(idle), 32'd1);
        check("rst_plot_we", 32'(fb_we), 32'd0);

        // Randomized traffic with random backpressure
        clear_stats();
        for (int i = 0; i < 2000; i++) begin
            plot     = ($urandom_range(0, 3) != 0);
            x        = 8'($urandom_range(0, 175));
            y        = 7'($urandom_range(0, 127));
            colour   = 3'($urandom_range(0, 7));
            fb_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        plot = 1'b0;
        drain("rand");
        check("rand_queue_empty", 32'(exp_q.size()), 32'd0);
        check("rand_drop", 32'(drop_count), 32'(drop_model));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
